// File: rtl/hog_pkg.sv
// Shared HOG pipeline constants: serializer bus width, window size and level count.
package hog_pkg;

  localparam int BUS_WIDTH        = 128;
  localparam int WINDOW_WIDTH     = 1152;
  localparam int BEATS_PER_WINDOW = WINDOW_WIDTH / BUS_WIDTH;
  localparam int LEVELS           = 8;

  // Index width for a 0..n-1 counter, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/burst_buf_mem.sv
// Simple dual-port storage array: one synchronous write port, one asynchronous read port.
module burst_buf_mem #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  // Contents are intentionally not reset; only the parent's pointers are.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/window_burst_buffer.sv
// Store-and-forward window buffer: releases a window only once all its beats are resident.
// Optional statistics counters are enabled with WINDOW_BURST_BUFFER_STATS_EN.
module window_burst_buffer #(
  parameter int DATA_WIDTH       = hog_pkg::BUS_WIDTH,
  parameter int DEPTH_LOG2       = 5,
  parameter int BEATS_PER_WINDOW = hog_pkg::BEATS_PER_WINDOW,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_stream,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_stream,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [DEPTH_LOG2:0]   windows_pending
`ifdef WINDOW_BURST_BUFFER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  windows_out,
  output logic [CNT_WIDTH-1:0]  stall_cycles
`endif
);

  localparam int BEAT_W = hog_pkg::idx_width(BEATS_PER_WINDOW);
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT  = (DEPTH_LOG2+1)'(1) << DEPTH_LOG2;
  localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(BEATS_PER_WINDOW - 1);

  // A window larger than the FIFO could never complete and would deadlock.
  if ((1 << DEPTH_LOG2) < BEATS_PER_WINDOW) begin : g_depth_chk
    $error("window_burst_buffer: 2**DEPTH_LOG2 must be >= BEATS_PER_WINDOW");
  end

  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [BEAT_W-1:0]     wr_beat, rd_beat;
  logic                  wr_en, rd_en, commit, release_win;

  assign in_ready    = (count < DEPTH_CNT);
  assign out_valid   = (windows_pending != '0);
  assign out_last    = out_valid && (rd_beat == LAST_BEAT);
  assign wr_en       = in_valid && in_ready;
  assign rd_en       = out_valid && out_ready;
  assign commit      = wr_en && (wr_beat == LAST_BEAT);
  assign release_win = rd_en && (rd_beat == LAST_BEAT);

  burst_buf_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (in_stream),
    .rd_addr (rd_ptr),
    .rd_data (out_stream)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      wr_beat         <= '0;
      rd_beat         <= '0;
      windows_pending <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr  <= wr_ptr + 1'b1;
        wr_beat <= (wr_beat == LAST_BEAT) ? '0 : wr_beat + 1'b1;
      end
      if (rd_en) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_beat <= (rd_beat == LAST_BEAT) ? '0 : rd_beat + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Commit and release in the same cycle cancel out.
      case ({commit, release_win})
        2'b10:   windows_pending <= windows_pending + 1'b1;
        2'b01:   windows_pending <= windows_pending - 1'b1;
        default: windows_pending <= windows_pending;
      endcase
    end
  end

`ifdef WINDOW_BURST_BUFFER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      windows_out  <= '0;
      stall_cycles <= '0;
    end else begin
      if (release_win) windows_out <= windows_out + 1'b1;
      if (out_valid && !out_ready && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end
`else
  // Statistics disabled: no counters or ports.
`endif

endmodule

// File: tb/tb_window_burst_buffer.sv
// Randomized and directed bench for window_burst_buffer against a queue-based window model.
module tb_window_burst_buffer;

  localparam int DW    = 128;
  localparam int DL2   = 5;
  localparam int BPW   = 9;
  localparam int DEPTH = 32;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_stream;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_stream;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [DL2:0]  windows_pending;
`ifdef WINDOW_BURST_BUFFER_STATS_EN
  logic [CW-1:0] windows_out;
  logic [CW-1:0] stall_cycles;
`endif

  window_burst_buffer #(
    .DATA_WIDTH (DW), .DEPTH_LOG2 (DL2), .BEATS_PER_WINDOW (BPW), .CNT_WIDTH (CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_stream       (in_stream),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .out_stream      (out_stream),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_last        (out_last),
    .windows_pending (windows_pending)
`ifdef WINDOW_BURST_BUFFER_STATS_EN
    ,
    .windows_out     (windows_out),
    .stall_cycles    (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: beats written/read since reset and the resident beat queue.
  int            wi, ro, m_wout, m_stall;
  logic [DW-1:0] q[$];

  function automatic int m_pend();
    return wi / BPW - ro / BPW;
  endfunction
  function automatic logic m_valid();
    return m_pend() > 0;
  endfunction
  function automatic logic m_last();
    return m_valid() && (ro % BPW == BPW - 1);
  endfunction
  function automatic logic m_ready();
    return (wi - ro) < DEPTH;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  task automatic check_model();
    chk("in_ready", DW'(in_ready), DW'(m_ready()));
    chk("out_valid", DW'(out_valid), DW'(m_valid()));
    chk("out_last", DW'(out_last), DW'(m_last()));
    chk("pending", DW'(windows_pending), DW'(m_pend()));
    if (m_valid()) chk("out_stream", out_stream, q[0]);
`ifdef WINDOW_BURST_BUFFER_STATS_EN
    chk("windows_out", DW'(windows_out), DW'(m_wout % (1 << CW)));
    chk("stall_cycles", DW'(stall_cycles), DW'((m_stall > 65535) ? 65535 : m_stall));
`endif
  endtask

  // Called at the negedge: drive, compare state, advance one clock, update model.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
    logic acc_w, acc_r, lst, vld;
    in_valid = v; in_stream = d; out_ready = r;
    check_model();
    vld   = m_valid();
    acc_w = v && m_ready();
    acc_r = vld && r;
    lst   = m_last();
    @(posedge clk);
    if (vld && !r) m_stall++;
    if (acc_r) begin
      void'(q.pop_front());
      ro++;
      if (lst) m_wout++;
    end
    if (acc_w) begin
      q.push_back(d);
      wi++;
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    wi = 0; ro = 0; m_wout = 0; m_stall = 0;
    q.delete();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"}, DW'(out_valid), '0);
    chk({tag, "_last"}, DW'(out_last), '0);
    chk({tag, "_ready"}, DW'(in_ready), DW'(1));
    chk({tag, "_pend"}, DW'(windows_pending), '0);
`ifdef WINDOW_BURST_BUFFER_STATS_EN
    chk({tag, "_wout"}, DW'(windows_out), '0);
    chk({tag, "_stall"}, DW'(stall_cycles), '0);
`endif
  endtask

  // Entered at a negedge; the reset is asserted between clock edges.
  task automatic do_reset(input string tag);
    in_valid = 1'b0; out_ready = 1'b0; in_stream = '0;
    #2 rst_n = 1'b0;
    #1 reset_checks(tag);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [DW-1:0] rnd_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int acc, cyc;
    logic [DW-1:0] d;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_stream = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    reset_checks("rst0");

    // One window back-to-back with downstream ready.
    for (int i = 1; i <= BPW; i++) begin
      chk("t1_idle_valid", DW'(out_valid), '0);
      step(1'b1, DW'(i), 1'b1);
    end
    chk("t1_valid_rise", DW'(out_valid), DW'(1));
    for (int i = 1; i <= BPW; i++) begin
      chk("t1_data", out_stream, DW'(i));
      chk("t1_last", DW'(out_last), DW'(i == BPW));
      chk("t1_pend", DW'(windows_pending), DW'(1));
      step(1'b0, '0, 1'b1);
    end
    chk("t1_pend_end", DW'(windows_pending), '0);

    // Partial window stays invisible until its final beat.
    for (int i = 0; i < BPW - 1; i++) step(1'b1, DW'(32'h100 + i), 1'b1);
    for (int i = 0; i < 20; i++) begin
      chk("t2_partial", DW'(out_valid), '0);
      step(1'b0, '0, 1'b1);
    end
    step(1'b1, DW'(32'h108), 1'b1);
    chk("t2_valid_rise", DW'(out_valid), DW'(1));
    for (int i = 0; i < BPW; i++) step(1'b0, '0, 1'b1);

    // Fill with downstream stalled, then drain.
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) acc++;
      step(1'b1, DW'(32'h1000 + i), 1'b0);
    end
    chk("t3_accepted", DW'(acc), DW'(32));
    chk("t3_full_ready", DW'(in_ready), '0);
    chk("t3_full_pend", DW'(windows_pending), DW'(3));
    step(1'b0, '0, 1'b1);
    chk("t3_ready_back", DW'(in_ready), DW'(1));
    for (int i = 0; i < 3 * BPW - 1; i++) step(1'b0, '0, 1'b1);
    chk("t3_drained_pend", DW'(windows_pending), '0);
    chk("t3_drained_valid", DW'(out_valid), '0);

    // Commit of window B coincides with release of window A.
    do_reset("rst1");
    for (int i = 0; i < 2 * BPW - 1; i++) step(1'b1, DW'(32'h2000 + i), 1'b0);
    for (int i = 0; i < BPW - 1; i++) step(1'b0, '0, 1'b1);
    chk("t4_last_before", DW'(out_last), DW'(1));
    step(1'b1, DW'(32'h2000 + 2 * BPW - 1), 1'b1);
    chk("t4_pend_hold", DW'(windows_pending), DW'(1));
    chk("t4_valid_hold", DW'(out_valid), DW'(1));
    chk("t4_next_first", out_stream, DW'(32'h2000 + BPW));
    for (int i = 0; i < BPW; i++) step(1'b0, '0, 1'b1);

    // Random valid/ready over 1000 windows.
    do_reset("rst2");
    cyc = 0;
    while (ro < 1000 * BPW && cyc < 60000) begin
      d = rnd_beat();
      step((wi < 1000 * BPW) ? 1'($urandom % 2) : 1'b0, d, 1'($urandom % 2));
      cyc++;
    end
    chk("t5_beats_out", DW'(ro), DW'(1000 * BPW));
    chk("t5_pend_end", DW'(windows_pending), '0);
`ifdef WINDOW_BURST_BUFFER_STATS_EN
    chk("t5_windows_out", DW'(windows_out), DW'(1000));
    chk("t5_stall", DW'(stall_cycles), DW'(m_stall));
`endif

    // Reset while window 2 is half-drained and window 3 partially written.
    do_reset("rst3");
    for (int i = 0; i < 2 * BPW; i++) step(1'b1, DW'(32'h3000 + i), 1'b0);
    for (int i = 0; i < BPW + 4; i++) step(i < 5, DW'(32'h3100 + i), 1'b1);
    chk("t6_pre_pend", DW'(windows_pending), DW'(1));
    do_reset("rst4");
    for (int i = 0; i < BPW; i++) step(1'b1, DW'(32'h4000 + i), 1'b1);
    chk("t6_new_first", out_stream, DW'(32'h4000));
    for (int i = 0; i < BPW + 1; i++) step(1'b0, '0, 1'b1);
    chk("t6_new_out", DW'(ro), DW'(BPW));
    chk("t6_pend_end", DW'(windows_pending), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
